sp_reader: RTL and testbench

- Bus-side read initiator for the matrix scratchpad.
- On a start command, it walks a contiguous element range of one scratchpad section. It drives the scratchpad's address and bus read-select lines and captures the registered row output one cycle later.
- Captured words are streamed out on a valid/ready interface with full backpressure.
- Used to drain systolic-array result matrices out of the scratchpad toward the host bus.

---
 rtl/sp_reader.sv | 177 +++++++++++++++++
 tb/tb_sp_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_reader.sv
// Scratchpad read initiator: walks one section's element range and streams the words out on valid/ready.
// Optional SP_READER_LAST_EN adds last_o, which flags the final word of each command.

module sp_reader_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];
endmodule

module sp_reader #(
  parameter int DW           = 8,
  parameter int BW           = 32,
  parameter int MAX_DIM      = BW / DW,
  parameter int SPN          = 1,
  parameter int ADDR_W       = 4,
  parameter int ELEMENTS_NUM = MAX_DIM * MAX_DIM
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        sp_sel_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] sp_addr_o,
  output logic [4:0]        sp_bus_mat_sel_o,
  input  logic [BW-1:0]     sp_row_i,
  output logic [BW-1:0]     data_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef SP_READER_LAST_EN
  ,
  output logic              last_o
`endif
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] ELEM_L = CW'(ELEMENTS_NUM);
  localparam logic [2:0]    SPN_L  = 3'(SPN);
`ifdef SP_READER_LAST_EN
  localparam int FW = BW + 1;
`else
  localparam int FW = BW;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     remaining;
  logic [1:0]        sel_q;
  logic              inflight;
  logic              inflight_last;
  logic              err_q;
  logic [1:0]        occ;
  logic [FW-1:0]     head;
  logic [FW-1:0]     push_dat;
  logic [CW-1:0]     range_end;
  logic [2:0]        used;
  logic              has_credit;
  logic              issue;
  logic              pop;
  logic              cmd_bad;
  logic              cmd_go;

  assign range_end = {1'b0, first_addr_i} + count_i;
  assign cmd_bad   = ({1'b0, sp_sel_i} >= SPN_L) || (range_end > ELEM_L);
  assign cmd_go    = (state == IDLE) && start_i && !cmd_bad;

  // Credit counts a word leaving this cycle, so a full stream sustains one word per cycle.
  assign valid_o    = (occ != 2'd0);
  assign pop        = valid_o && ready_i;
  assign used       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign has_credit = (used < 3'd2);

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_i && !cmd_bad) next_state = (count_i == '0) ? DONE : ISSUE;
      ISSUE: if (has_credit && remaining == CW'(1)) next_state = DRAIN;
      DRAIN: if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    issue            = (state == ISSUE) && has_credit;
    busy_o           = (state == ISSUE) || (state == DRAIN);
    done_o           = (state == DONE);
    sp_addr_o        = '0;
    sp_bus_mat_sel_o = 5'd0;
    if (issue) begin
      sp_addr_o        = addr_q;
      sp_bus_mat_sel_o = {1'b1, sel_q, 2'b00};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q        <= '0;
      remaining     <= '0;
      sel_q         <= 2'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start_i && cmd_bad;
      if (cmd_go) begin
        addr_q    <= first_addr_i;
        remaining <= count_i;
        sel_q     <= sp_sel_i;
      end else if (issue) begin
        addr_q    <= addr_q + 1'b1;
        remaining <= remaining - 1'b1;
      end
      inflight      <= issue;
      inflight_last <= issue && (remaining == CW'(1));
    end
  end

  assign err_o = err_q;

`ifdef SP_READER_LAST_EN
  assign push_dat = {inflight_last, sp_row_i};
  assign last_o   = valid_o && head[BW];
`else
  assign push_dat = sp_row_i;
`endif

  sp_reader_fifo #(.W(FW)) u_fifo (
    .clk      (clk_i),
    .reset    (reset_i),
    .push     (inflight),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .occ      (occ)
  );

  // Gate with valid so an empty buffer presents zero rather than stale data.
  assign data_o = valid_o ? head[BW-1:0] : '0;
endmodule

// File: tb/tb_sp_reader.sv
// Directed bench for sp_reader: one SPN=1 and one SPN=2 instance share stimulus and a scratchpad model.
module tb_sp_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  sp_sel;
  logic [3:0]  first;
  logic [4:0]  count;
  logic        ready;
  logic        mon_b;

  logic        a_busy, a_done, a_err, a_valid, b_busy, b_done, b_err, b_valid;
  logic [3:0]  a_addr, b_addr;
  logic [4:0]  a_msel, b_msel;
  logic [31:0] a_row, b_row, a_data, b_data;
`ifdef SP_READER_LAST_EN
  logic        a_last, b_last, o_last;
`endif

  logic        o_valid, o_busy, o_done, o_err;
  logic [31:0] o_data;
  logic [3:0]  o_addr;
  logic [4:0]  o_sel;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sp_reader #(.SPN(1)) u_a (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sp_sel_i(sp_sel),
    .first_addr_i(first), .count_i(count), .busy_o(a_busy), .done_o(a_done),
    .err_o(a_err), .sp_addr_o(a_addr), .sp_bus_mat_sel_o(a_msel), .sp_row_i(a_row),
    .data_o(a_data), .valid_o(a_valid), .ready_i(ready)
`ifdef SP_READER_LAST_EN
    , .last_o(a_last)
`endif
  );

  sp_reader #(.SPN(2)) u_b (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sp_sel_i(sp_sel),
    .first_addr_i(first), .count_i(count), .busy_o(b_busy), .done_o(b_done),
    .err_o(b_err), .sp_addr_o(b_addr), .sp_bus_mat_sel_o(b_msel), .sp_row_i(b_row),
    .data_o(b_data), .valid_o(b_valid), .ready_i(ready)
`ifdef SP_READER_LAST_EN
    , .last_o(b_last)
`endif
  );

  // Scratchpad: section 0 holds 0x100+k, section 1 holds 0xA0+k, select 0 returns 0.
  function automatic logic [31:0] spm(input logic [4:0] s, input logic [3:0] a);
    case (s)
      5'd16:   return 32'h100 + {28'd0, a};
      5'd20:   return 32'h0A0 + {28'd0, a};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    a_row <= spm(a_msel, a_addr);
    b_row <= spm(b_msel, b_addr);
  end

  always_comb begin
    o_valid = mon_b ? b_valid : a_valid;
    o_busy  = mon_b ? b_busy  : a_busy;
    o_done  = mon_b ? b_done  : a_done;
    o_err   = mon_b ? b_err   : a_err;
    o_data  = mon_b ? b_data  : a_data;
    o_addr  = mon_b ? b_addr  : a_addr;
    o_sel   = mon_b ? b_msel  : a_msel;
`ifdef SP_READER_LAST_EN
    o_last  = mon_b ? b_last  : a_last;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_valid"}, 32'(a_valid), 32'd0);
    chk({pfx, "_data"},  a_data, 32'd0);
    chk({pfx, "_busy"},  32'(a_busy), 32'd0);
    chk({pfx, "_done"},  32'(a_done), 32'd0);
    chk({pfx, "_err"},   32'(a_err), 32'd0);
    chk({pfx, "_msel"},  32'(a_msel), 32'd0);
    chk({pfx, "_addr"},  32'(a_addr), 32'd0);
  endtask

  // rmode 0: ready held high; rmode 1: ready pattern 1,0,0,1. poke re-strobes start while busy.
  task automatic run_cmd(input logic [1:0] s, input logic [3:0] f, input logic [4:0] n,
                         input int rmode, input bit poke, input bit exp_err, input int exp_n,
                         input logic [31:0] exp_base, input logic [4:0] exp_sel);
    int nw = 0, nreq = 0, ndone = 0, nerr = 0;
    int done_c = -1, err_c = -1, first_x = -1, last_x = -1;
    bit busy0 = 0, busy_at_done = 0, pv = 0, pr = 0;
    logic [31:0] pd = 0;
    @(posedge clk); #1;
    start = 1'b1; sp_sel = s; first = f; count = n; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      ready = (rmode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (poke && c == 4) begin
        start = 1'b1; sp_sel = 2'd0; first = 4'd8; count = 5'd2;
      end
      if (poke && c == 5) start = 1'b0;
      @(negedge clk);
      if (c == 0) busy0 = o_busy;
      if (pv && !pr) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", o_data, pd);
      end
      if (o_sel != 5'd0) begin
        chk("req_sel", 32'(o_sel), 32'(exp_sel));
        chk("req_addr", 32'(o_addr), 32'(f) + nreq);
        nreq++;
      end else begin
        chk("idle_addr", 32'(o_addr), 32'd0);
      end
      if (o_valid && ready) begin
        chk("word", o_data, exp_base + nw);
`ifdef SP_READER_LAST_EN
        chk("last", 32'(o_last), 32'(nw == exp_n - 1));
`endif
        if (first_x < 0) first_x = c;
        last_x = c;
        nw++;
      end
      if (o_done) begin ndone++; done_c = c; busy_at_done = o_busy; end
      if (o_err)  begin nerr++;  err_c = c; end
      pv = o_valid; pr = ready; pd = o_data;
      @(posedge clk); #1;
    end
    chk("n_words", nw, exp_n);
    chk("n_req", nreq, exp_n);
    chk("n_done", ndone, exp_err ? 0 : 1);
    chk("n_err", nerr, exp_err ? 1 : 0);
    chk("busy_c0", 32'(busy0), 32'(!exp_err && exp_n > 0));
    if (exp_err) begin
      chk("err_cyc", err_c, 0);
    end else begin
      chk("busy_at_done", 32'(busy_at_done), 32'd0);
      chk("done_cyc", done_c, (exp_n == 0) ? 0 : last_x + 1);
    end
    if (rmode == 0 && exp_n > 0) begin
      chk("first_xfer", first_x, 2);
      chk("last_xfer", last_x, exp_n + 1);
    end
  endtask

  task automatic reset_abort();
    int n = 0, ndone = 0;
    bit hit = 0;
    mon_b = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; sp_sel = 2'd0; first = 4'd0; count = 5'd16; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (a_valid && ready) n++;
      if (n == 5) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("abort_reached", 32'(hit), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("abort");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sp_sel = 2'd0; first = 4'd0; count = 5'd0;
    ready = 1'b1; mon_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    run_cmd(2'd0, 4'd0,  5'd16, 0, 1'b0, 1'b0, 16, 32'h100, 5'd16);
    run_cmd(2'd0, 4'd0,  5'd16, 1, 1'b0, 1'b0, 16, 32'h100, 5'd16);
    run_cmd(2'd0, 4'd14, 5'd3,  0, 1'b0, 1'b1, 0,  32'h0,   5'd0);
    run_cmd(2'd1, 4'd4,  5'd4,  0, 1'b0, 1'b1, 0,  32'h0,   5'd0);
    mon_b = 1'b1;
    run_cmd(2'd1, 4'd4,  5'd4,  0, 1'b0, 1'b0, 4,  32'h0A4, 5'd20);
    run_cmd(2'd2, 4'd0,  5'd1,  0, 1'b0, 1'b1, 0,  32'h0,   5'd0);
    mon_b = 1'b0;
    run_cmd(2'd0, 4'd5,  5'd0,  0, 1'b0, 1'b0, 0,  32'h0,   5'd0);
    run_cmd(2'd0, 4'd0,  5'd16, 0, 1'b1, 1'b0, 16, 32'h100, 5'd16);
    run_cmd(2'd0, 4'd12, 5'd4,  1, 1'b0, 1'b0, 4,  32'h10C, 5'd16);
    run_cmd(2'd0, 4'd15, 5'd1,  0, 1'b0, 1'b0, 1,  32'h10F, 5'd16);
    reset_abort();
    run_cmd(2'd0, 4'd3,  5'd5,  0, 1'b0, 1'b0, 5,  32'h103, 5'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
